// File: rtl/scope_pkg.sv
// ---------------------------------------------------------------------------
// scope_pkg
// Shared definitions for the ADC SPI reader: FSM state type, frame geometry
// and default parameter values, plus small state-decode helpers used by the
// top level to derive its registered outputs.
// ---------------------------------------------------------------------------
package scope_pkg;

    // Frame geometry: every ADC frame is 16 SCLK periods long.
    localparam int FRAME_BITS   = 16;
    localparam int HALF_PERIODS = 2 * FRAME_BITS;

    // Default parameter values for adc_spi_reader.
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_LEAD_BITS = 3;
    localparam int DEF_DATA_BITS = 8;

    // Encodings are fixed so that existing debug tooling reading the raw
    // state value keeps working.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_WAIT     = 3'd4
    } state_t;

    // Chip select is asserted from setup through hold; released in IDLE/WAIT.
    function automatic logic cs_active(input state_t s);
        return (s == ST_CS_SETUP) || (s == ST_SHIFT) || (s == ST_CS_HOLD);
    endfunction

    // Divider runs freely only while a timed phase is in progress.
    function automatic logic divider_hold(input state_t s);
        return (s == ST_IDLE) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Generates the SCLK half-period tick: 'tick' is high in the last clk cycle
// of every CLK_DIV-cycle window. 'clear' preloads the counter so that the
// first window after clear is a full CLK_DIV cycles long.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (counter to 0)
//   clear : synchronous reload to CLK_DIV-1
//   tick  : window-end strobe
// ---------------------------------------------------------------------------
module tick_divider
    import scope_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [3:0] RELOAD = 4'(CLK_DIV - 1);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear || (count == '0)) begin
            count <= RELOAD;
        end else begin
            count <= count - 4'd1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/adc_spi_reader.sv
// ---------------------------------------------------------------------------
// adc_spi_reader
// Periodically reads a serial ADC: drives chip select and SCLK, samples
// adc_miso on every SCLK rising edge, checks the leading bits for zero and
// assembles a DATA_BITS sample MSB first. Each completed frame produces a
// one-cycle sample_valid strobe, followed by rate_div+1 idle cycles.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   enable       : start/continue conversions while high
//   rate_div     : extra idle cycles between frames (latched per frame)
//   adc_miso     : serial data from ADC (already synchronised)
//   adc_cs_n     : ADC chip select, active low
//   adc_sclk     : ADC serial clock, idle high
//   sample_data  : last captured sample
//   sample_valid : one-cycle strobe when sample_data/sample_err update
//   sample_err   : a leading bit of the last frame was 1
//   busy         : high in every state except IDLE
// ---------------------------------------------------------------------------
module adc_spi_reader
    import scope_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int LEAD_BITS = DEF_LEAD_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [7:0]           rate_div,
    input  logic                 adc_miso,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 sample_valid,
    output logic                 sample_err,
    output logic                 busy
);

    localparam logic [4:0] LAST_HALF = 5'(HALF_PERIODS - 1);

    state_t               state;
    state_t               state_n;
    logic [4:0]           half;
    logic [4:0]           half_n;
    logic [7:0]           wait_cnt;
    logic [7:0]           wait_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 err_acc;
    logic                 err_n;
    logic                 tick;
    logic                 div_clear;
    logic                 capture;
    logic [3:0]           bit_idx;
    logic                 frame_done;

    // Divider is held in reload outside the timed phases, so CS_SETUP always
    // starts with a full CLK_DIV window; between phases it reloads by itself.
    assign div_clear = divider_hold(state);

    tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .tick  (tick)
    );

    // Even half-periods have SCLK low; the tick ending one is the edge where
    // SCLK goes 0->1, which is when the ADC bit is taken.
    assign bit_idx    = half[4:1];
    assign capture    = (state == ST_SHIFT) && tick && !half[0];
    assign frame_done = (state == ST_CS_HOLD) && tick;

    always_comb begin
        state_n = state;
        half_n  = half;
        wait_n  = wait_cnt;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_n = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (tick) begin
                    state_n = ST_SHIFT;
                    half_n  = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (half == LAST_HALF) begin
                        state_n = ST_CS_HOLD;
                    end else begin
                        half_n = half + 5'd1;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (tick) begin
                    state_n = ST_WAIT;
                    wait_n  = rate_div;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_n = enable ? ST_CS_SETUP : ST_IDLE;
                end else begin
                    wait_n = wait_cnt - 8'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Frame accumulators: cleared during setup, fed on each SCLK rising edge.
    always_comb begin
        shreg_n = shreg;
        err_n   = err_acc;
        if (state == ST_CS_SETUP) begin
            shreg_n = '0;
            err_n   = 1'b0;
        end else if (capture) begin
            if (int'(bit_idx) < LEAD_BITS) begin
                err_n = err_acc | adc_miso;
            end else if (int'(bit_idx) < LEAD_BITS + DATA_BITS) begin
                shreg_n    = shreg << 1;
                shreg_n[0] = adc_miso;
            end
        end
    end

    // Outputs are registered from the next-state decode so they change
    // together with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            half         <= '0;
            wait_cnt     <= '0;
            shreg        <= '0;
            err_acc      <= 1'b0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b1;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            sample_err   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            half         <= half_n;
            wait_cnt     <= wait_n;
            shreg        <= shreg_n;
            err_acc      <= err_n;
            adc_cs_n     <= !cs_active(state_n);
            adc_sclk     <= (state_n == ST_SHIFT) ? half_n[0] : 1'b1;
            busy         <= (state_n != ST_IDLE);
            sample_valid <= frame_done;
            if (frame_done) begin
                sample_data <= shreg;
                sample_err  <= err_acc;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_reader
// Directed bench for adc_spi_reader (CLK_DIV=2, LEAD_BITS=3, DATA_BITS=8).
// A behavioural ADC shifts out a 16-bit frame, one bit per SCLK rising edge,
// restarting at every chip-select assertion.
// ---------------------------------------------------------------------------
module tb_adc_spi_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] rate_div;
    logic       adc_miso;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_err;
    logic       busy;

    always #5 clk = ~clk;

    adc_spi_reader #(
        .CLK_DIV   (2),
        .LEAD_BITS (3),
        .DATA_BITS (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rate_div     (rate_div),
        .adc_miso     (adc_miso),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_err   (sample_err),
        .busy         (busy)
    );

    // ADC model: frame bit 0 sits at adc_frame[15].
    logic [15:0] adc_frame = 16'h0000;
    int rise_total  = 0;
    int rise_base   = 0;
    int cs_fall_cnt = 0;
    int valid_cnt   = 0;
    int errors      = 0;
    int checks      = 0;

    always @(posedge adc_sclk) rise_total <= rise_total + 1;

    always @(negedge adc_cs_n) begin
        rise_base   <= rise_total;
        cs_fall_cnt <= cs_fall_cnt + 1;
    end

    always @(posedge clk) begin
        if (sample_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    end

    always_comb begin
        int bi;
        bi = rise_total - rise_base;
        adc_miso = (bi >= 0 && bi < 16) ? adc_frame[4'(15 - bi)] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until sample_valid is seen; returns budget+1 on timeout.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sample_valid !== 1'b1 && n <= budget);
    endtask

    initial begin
        int n;
        int v0;
        int f0;

        // Reset held two cycles with enable high.
        rst       = 1'b1;
        enable    = 1'b1;
        rate_div  = 8'd0;
        adc_frame = 16'h14A0;           // 000_10100101_00000
        step(2);
        check("rst_cs_n",  32'(adc_cs_n),     32'd1);
        check("rst_sclk",  32'(adc_sclk),     32'd1);
        check("rst_data",  32'(sample_data),  32'h00);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_err",   32'(sample_err),   32'd0);

        rst    = 1'b0;
        enable = 1'b0;
        step(3);
        check("idle_busy", 32'(busy),     32'd0);
        check("idle_cs_n", 32'(adc_cs_n), 32'd1);

        // First frame from IDLE.
        enable = 1'b1;
        wait_valid(200, n);
        check("first_latency", 32'(n),           32'd69);
        check("f1_data",       32'(sample_data), 32'hA5);
        check("f1_err",        32'(sample_err),  32'd0);
        check("f1_cs_n",       32'(adc_cs_n),    32'd1);
        check("f1_busy",       32'(busy),        32'd1);
        check("f1_rises",      32'(rise_total - rise_base), 32'd16);

        // rate_div changed after WAIT entry: current wait still uses 0.
        rate_div = 8'd10;
        wait_valid(200, n);
        check("f2_period", 32'(n),           32'd69);
        check("f2_data",   32'(sample_data), 32'hA5);
        check("f2_rises",  32'(rise_total - rise_base), 32'd16);

        wait_valid(200, n);
        check("f3_period", 32'(n),           32'd79);
        check("f3_data",   32'(sample_data), 32'hA5);
        check("f3_rises",  32'(rise_total - rise_base), 32'd16);

        // Leading-bit error frame, then a clean one.
        adc_frame = 16'h4780;           // 010_00111100_00000
        wait_valid(200, n);
        check("f4_period", 32'(n),           32'd79);
        check("f4_data",   32'(sample_data), 32'h3C);
        check("f4_err",    32'(sample_err),  32'd1);

        adc_frame = 16'h0B40;           // 000_01011010_00000
        wait_valid(200, n);
        check("f5_period", 32'(n),           32'd79);
        check("f5_data",   32'(sample_data), 32'h5A);
        check("f5_err",    32'(sample_err),  32'd0);

        // 30 cycles later: mid-SHIFT, previous sample held.
        step(30);
        check("hold_data",  32'(sample_data),  32'h5A);
        check("hold_err",   32'(sample_err),   32'd0);
        check("hold_valid", 32'(sample_valid), 32'd0);
        check("shift_cs_n", 32'(adc_cs_n),     32'd0);

        // Drop enable mid-SHIFT: frame completes, then IDLE.
        v0 = valid_cnt;
        f0 = cs_fall_cnt;
        enable = 1'b0;
        wait_valid(200, n);
        check("drop_remaining", 32'(n),           32'd49);
        check("drop_data",      32'(sample_data), 32'h5A);
        step(20);
        check("drop_busy", 32'(busy),     32'd0);
        check("drop_cs_n", 32'(adc_cs_n), 32'd1);
        check("drop_sclk", 32'(adc_sclk), 32'd1);
        step(100);
        check("drop_no_cs",   32'(cs_fall_cnt), 32'(f0));
        check("drop_one_val", 32'(valid_cnt),   32'(v0 + 1));

        // Reset during SHIFT bit 7.
        adc_frame = 16'h1860;           // 000_11000011_00000
        enable = 1'b1;
        step(31);
        check("b7_cs_n", 32'(adc_cs_n), 32'd0);
        check("b7_sclk", 32'(adc_sclk), 32'd0);
        v0 = valid_cnt;
        rst = 1'b1;
        step(1);
        check("mrst_cs_n",  32'(adc_cs_n),     32'd1);
        check("mrst_sclk",  32'(adc_sclk),     32'd1);
        check("mrst_busy",  32'(busy),         32'd0);
        check("mrst_valid", 32'(sample_valid), 32'd0);
        check("mrst_data",  32'(sample_data),  32'h00);
        rst = 1'b0;
        wait_valid(200, n);
        check("mrst_no_val", 32'(valid_cnt),   32'(v0));
        check("post_lat",    32'(n),           32'd69);
        check("post_data",   32'(sample_data), 32'hC3);
        check("post_err",    32'(sample_err),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
